// File: rtl/gray_pattern_sequencer_pkg.sv
// Shared types and constants for the Gray pattern sequencer.
// Mode 2 legality follows GRAY_SEQ_BOUNCE_EN.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_UP     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_DOWN   = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BOUNCE = 2'd2;
  localparam logic [MODE_W-1:0] MODE_RSVD   = 2'd3;

  function automatic logic mode_supported(input logic [MODE_W-1:0] mode);
    logic ok;
    ok = 1'b0;
    case (mode)
      MODE_UP, MODE_DOWN: ok = 1'b1;
`ifdef GRAY_SEQ_BOUNCE_EN
      MODE_BOUNCE:        ok = 1'b1;
`else
      MODE_BOUNCE:        ok = 1'b0;
`endif
      default:            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/gray_pattern_sequencer_if.sv
// Command and output handshake bundle of the sequencer.
// master drives commands and out_ready, slave is the sequencer itself.
interface gray_pattern_sequencer_if
  import gray_seq_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int REPS_W = 8
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [WIDTH-1:0]  cfg_lo;
  logic [WIDTH-1:0]  cfg_hi;
  logic [MODE_W-1:0] cfg_mode;
  logic [REPS_W-1:0] cfg_reps;
  logic              stop;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_bin;
  logic [WIDTH-1:0]  out_gray;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cfg_valid, cfg_lo, cfg_hi, cfg_mode, cfg_reps, stop, out_ready,
    input  cfg_ready, out_valid, out_bin, out_gray, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_lo, cfg_hi, cfg_mode, cfg_reps, stop, out_ready,
    output cfg_ready, out_valid, out_bin, out_gray, busy, done, err
  );

endinterface

// File: rtl/gray_pattern_sequencer_b2g.sv
// Combinational binary to reflected-Gray converter.
module Binary2Gray #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [WIDTH-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/gray_pattern_sequencer.sv
// Bounded up/down/bounce pattern counter with output back-pressure and Gray view.
// Bounce mode is present only when GRAY_SEQ_BOUNCE_EN is defined.
module gray_pattern_sequencer
  import gray_seq_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int REPS_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gray_pattern_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  localparam logic [WIDTH-1:0]  BIN_ONE  = WIDTH'(1);
  localparam logic [REPS_W-1:0] PASS_ONE = REPS_W'(1);

  logic [1:0]        r_state;
  logic [WIDTH-1:0]  r_lo;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_bin;
  logic [MODE_W-1:0] r_mode;
  logic [REPS_W-1:0] r_reps;
  logic [REPS_W-1:0] r_pass;
  logic              r_down;
  logic              r_err;

  logic              w_idle;
  logic              w_run;
  logic              w_cfg_ok;
  logic              w_xfer;
  logic [WIDTH-1:0]  w_next;
  logic              w_next_down;
  logic              w_pass_end;
  logic [REPS_W-1:0] w_pass_inc;
  logic              w_last;
  logic [WIDTH-1:0]  w_start;

  assign w_idle     = (r_state == S_IDLE);
  assign w_run      = (r_state == S_RUN);
  assign w_cfg_ok   = (bus.cfg_lo <= bus.cfg_hi) && mode_supported(bus.cfg_mode);
  assign w_xfer     = w_run && bus.out_ready;
  assign w_pass_inc = r_pass + PASS_ONE;
  assign w_last     = w_pass_end && (r_reps != '0) && (w_pass_inc == r_reps);
  assign w_start    = (bus.cfg_mode == MODE_DOWN) ? bus.cfg_hi : bus.cfg_lo;

  // Next value is chosen by comparing against the bounds before stepping, so
  // the counter can never wrap even when a bound sits at 0 or at all-ones.
  always_comb begin
    w_next      = r_bin;
    w_next_down = r_down;
    w_pass_end  = 1'b0;
    case (r_mode)
      MODE_DOWN: begin
        if (r_bin == r_lo) begin
          w_pass_end = 1'b1;
          w_next     = r_hi;
        end else begin
          w_next = r_bin - BIN_ONE;
        end
      end
`ifdef GRAY_SEQ_BOUNCE_EN
      MODE_BOUNCE: begin
        if (!r_down) begin
          if (r_bin == r_hi) begin
            if (r_lo == r_hi) begin
              w_pass_end = 1'b1;
              w_next     = r_lo;
            end else begin
              w_next      = r_bin - BIN_ONE;
              w_next_down = 1'b1;
            end
          end else begin
            w_next = r_bin + BIN_ONE;
          end
        end else begin
          if (r_bin == r_lo) begin
            w_pass_end  = 1'b1;
            w_next      = r_lo;
            w_next_down = 1'b0;
          end else begin
            w_next = r_bin - BIN_ONE;
          end
        end
      end
`endif
      default: begin
        if (r_bin == r_hi) begin
          w_pass_end = 1'b1;
          w_next     = r_lo;
        end else begin
          w_next = r_bin + BIN_ONE;
        end
      end
    endcase
  end

  // The final beat leaves out_bin on the last delivered value rather than
  // stepping to the next pass start, so IDLE shows what was last consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_bin   <= '0;
      r_mode  <= MODE_UP;
      r_reps  <= '0;
      r_pass  <= '0;
      r_down  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_valid) begin
            if (w_cfg_ok) begin
              r_lo    <= bus.cfg_lo;
              r_hi    <= bus.cfg_hi;
              r_mode  <= bus.cfg_mode;
              r_reps  <= bus.cfg_reps;
              r_bin   <= w_start;
              r_pass  <= '0;
              r_down  <= 1'b0;
              r_err   <= 1'b0;
              r_state <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
          end else if (w_xfer) begin
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              r_bin  <= w_next;
              r_down <= w_next_down;
              if (w_pass_end) begin
                r_pass <= w_pass_inc;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready = w_idle;
  assign bus.out_valid = w_run;
  assign bus.busy      = w_run;
  assign bus.done      = (r_state == S_DONE);
  assign bus.err       = r_err;
  assign bus.out_bin   = r_bin;

  Binary2Gray #(.WIDTH(WIDTH)) u_b2g (
    .i_bin  (r_bin),
    .o_gray (bus.out_gray)
  );

endmodule
